// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry and clear/run state type shared by the register file slice.
package regfile_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: post-reset sweep that zeroes every register from index 1 upward, then raises ready.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    output logic                      clr_en,
    output logic [REG_ADDR_WIDTH-1:0] clr_idx
);
    state_t state;
    assign clr_en = state == CLEAR;
    // ready lags the CLEAR->RUN transition by one edge so the last index is settled first
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= REG_ADDR_WIDTH'(1);
            ready   <= 1'b0;
        end else begin
            state   <= (state == CLEAR && clr_idx == '1) ? RUN : state;
            clr_idx <= state == CLEAR ? clr_idx + 1'b1 : clr_idx;
            ready   <= state == RUN;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-write scoreboard and post-reset clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy state to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int NUM_RD         = 2,
    parameter int DEBUG_REG      = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             busy_set,
    input  logic [REG_ADDR_WIDTH-1:0]        busy_addr,
    output logic                             ready,
    output logic [DATA_WIDTH-1:0]            a0
);
    localparam int DEPTH = 2**REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] DBG = REG_ADDR_WIDTH'(DEBUG_REG);
    logic [DATA_WIDTH-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]          pending, set_mask, clr_mask;
    logic                      clr_en, we;
    logic [REG_ADDR_WIDTH-1:0] clr_idx;
    regfile_clear_fsm #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );
    assign we       = wr_en && ready && wr_addr != '0;
    assign set_mask = (busy_set && ready && busy_addr != '0) ? DEPTH'(1) << busy_addr : '0;
    assign clr_mask = we ? DEPTH'(1) << wr_addr : '0;
    // set is OR'd in after the clear so a same-cycle claim stays pending
    always_ff @(posedge clk) begin
        pending <= rst ? '0 : (pending & ~clr_mask) | set_mask;
    end
    always_ff @(posedge clk) begin
        if (clr_en)
            regs[clr_idx] <= '0;
        else if (we)
            regs[wr_addr] <= wr_data;
    end
    assign a0 = ready ? regs[DBG] : '0;
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [REG_ADDR_WIDTH-1:0] a;
        logic                      hit;
        assign a = rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
        assign hit = we && wr_addr == a;
`else
        assign hit = 1'b0;
`endif
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = (!ready || a == '0) ? '0 : hit ? wr_data : regs[a];
        assign rd_busy[i] = ready && (hit ? set_mask[a] : pending[a]);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sequence, reads/writes, scoreboard, forwarding and mid-clear reset.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy_set = 1'b0;
    logic [4:0]  busy_addr = '0;
    logic        ready;
    logic [31:0] a0;
    int checks = 0;
    int failures = 0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .ready     (ready),
        .a0        (a0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
            if (n == 5) begin
                wr_en = 1'b0;
                busy_set = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        int bad;
        tick();
        tick();
        rd_addr = {5'd10, 5'd5};
        chk("rst_ready", ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_a0", a0, 0);
        rst = 1'b0;
        wait_ready(n);
        chk("ready_latency", n, 32);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            rd_addr = {5'(31 - k), 5'(k)};
            #1;
            if (rd_data != 0) bad++;
        end
        chk("all_zero_after_clear", bad, 0);
        // write 5, read on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 5'd0; wr_data = 32'h1;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd5, 5'd5};
        #1;
        chk("p0_idx5", rd_data[31:0], 32'hDEADBEEF);
        chk("p1_idx5", rd_data[63:32], 32'hDEADBEEF);
        rd_addr = {5'd5, 5'd0};
        #1;
        chk("idx0_reads0", rd_data[31:0], 0);
        // scoreboard: claim 7, idle, then write
        busy_set = 1'b1; busy_addr = 5'd7;
        rd_addr = {5'd3, 5'd7};
        tick();
        busy_set = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("busy7_idle", rd_busy[0], 1);
            tick();
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        #1;
        chk("busy7_write_cycle", rd_busy[0], BYP ? 0 : 1);
        tick();
        wr_en = 1'b0;
        chk("busy7_after_write", rd_busy[0], 0);
        chk("data7", rd_data[31:0], 32'h77);
        // same-cycle set and write: set wins
        busy_set = 1'b1; busy_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h99;
        #1;
        chk("same_cycle_busy_comb", rd_busy[0], BYP ? 1 : 0);
        tick();
        busy_set = 1'b0; wr_en = 1'b0;
        chk("same_cycle_busy", rd_busy[0], 1);
        chk("same_cycle_data", rd_data[31:0], 32'h99);
        busy_set = 1'b1; busy_addr = 5'd3;
        tick();
        busy_set = 1'b0;
        chk("busy3_port1", rd_busy[1], 1);
        // forwarding on index 10
        rd_addr = {5'd10, 5'd10};
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55;
        #1;
        chk("fwd_p0", rd_data[31:0], BYP ? 32'h55 : 32'h0);
        chk("fwd_p1", rd_data[63:32], BYP ? 32'h55 : 32'h0);
        chk("a0_before", a0, 0);
        tick();
        wr_en = 1'b0;
        chk("idx10_after", rd_data[31:0], 32'h55);
        chk("a0_after", a0, 32'h55);
        // reset, restart mid-clear at index 12, writes during clear are lost
        rst = 1'b1;
        rd_addr = {5'd3, 5'd10};
        tick();
        chk("rst_a0_zero", a0, 0);
        chk("rst_rd_zero", rd_data[31:0], 0);
        chk("rst_busy_zero", rd_busy, 0);
        rst = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        chk("midclear_not_ready", ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAAAA;
        busy_set = 1'b1; busy_addr = 5'd3;
        wait_ready(n);
        chk("restart_latency", n, 32);
        rd_addr = {5'd3, 5'd10};
        #1;
        chk("lost_write_idx10", rd_data[31:0], 0);
        chk("lost_write_a0", a0, 0);
        chk("ignored_busy_set", rd_busy, 0);
        rd_addr = {5'd7, 5'd5};
        #1;
        chk("recleared_5_7", rd_data, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
